// File: rtl/hqm_aw_rr_dwrr_arb_pipe_pkg.sv
// rtl/hqm_aw_rr_dwrr_arb_pipe_pkg.sv - shared types and helpers for the RR/DWRR arbiter pipe
package hqm_aw_rr_dwrr_arb_pipe_pkg;

  typedef enum logic {HQM_AW_ARB_STRICT = 1'b0, HQM_AW_ARB_DWRR = 1'b1} aw_arb_mode_t;

  localparam int HQM_AW_ARB_CREDIT_W = 9;

  // floor(log2(x)); 0 and 1 both map to 0
  function automatic int aw_logb2(input int x);
    int r;
    r = 0;
    for (int v = x; v > 1; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/hqm_aw_rr_dwrr_arb_pipe_pick_first.sv
// rtl/hqm_aw_rr_dwrr_arb_pipe_pick_first.sv - find-first-set starting after i_idx, wrapping
module hqm_aw_rr_dwrr_arb_pipe_pick_first #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_idx,
  output logic         o_valid,
  output logic [W-1:0] o_sel
);

  // Walk from the farthest position back so the nearest set bit after i_idx lands last
  always_comb begin
    int pos;
    o_sel = '0;
    pos   = 0;
    for (int k = N; k >= 1; k--) begin
      pos = (int'(i_idx) + k) % N;
      if (i_req[pos[W-1:0]]) o_sel = pos[W-1:0];
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/hqm_aw_rr_dwrr_arb_pipe.sv
// rtl/hqm_aw_rr_dwrr_arb_pipe.sv - two-stage RR + strict/DWRR arbiter with registered valid/ready output
// Optional starvation override enabled by defining HQM_AW_RR_DWRR_ARB_STARVE_EN.
module hqm_aw_rr_dwrr_arb_pipe
  import hqm_aw_rr_dwrr_arb_pipe_pkg::*;
#(
  parameter int NUM_REQS   = 8,
  parameter int NUM_PRI    = 8,
  parameter int NUM_REQSB2 = aw_logb2(NUM_REQS - 1) + 1,
  parameter int NUM_PRIB2  = aw_logb2(NUM_PRI - 1) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_mode,
  input  logic [NUM_PRI*8-1:0]         cfg_weight,
  input  logic [7:0]                   cfg_starve_thresh,
  input  logic [NUM_PRI*NUM_REQS-1:0]  reqs,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PRIB2-1:0]         winner_pri,
  output logic [NUM_REQSB2-1:0]        winner,
  output logic                         winner_boosted
);

  localparam int CW = HQM_AW_ARB_CREDIT_W;

  logic [NUM_PRI-1:0][NUM_REQSB2-1:0] r_idx;
  logic [NUM_PRI-1:0][CW-1:0]         r_cred;
  logic                               r_valid;
  logic [NUM_PRIB2-1:0]               r_pri;
  logic [NUM_REQSB2-1:0]              r_win;
  logic                               r_boost;

  logic                               w_load;
  logic [NUM_PRI-1:0]                 w_pri_any;
  logic [NUM_PRI-1:0][NUM_REQSB2-1:0] w_s1_sel;
  logic [NUM_PRI-1:0]                 w_cand;
  logic [NUM_PRI-1:0]                 w_boost;
  logic [NUM_PRI-1:0][CW-1:0]         w_reload_val;
  logic                               w_any;
  logic                               w_strict_any;
  logic [NUM_PRIB2-1:0]               w_strict_sel;
  logic                               w_cand_any;
  logic [NUM_PRIB2-1:0]               w_cand_sel;
  logic                               w_boost_any;
  logic [NUM_PRIB2-1:0]               w_boost_sel;
  logic [NUM_PRIB2-1:0]               w_sel_pri;
  logic [NUM_REQSB2-1:0]              w_win_req;
  logic [NUM_PRI-1:0]                 w_win_oh;
  logic                               w_boost_win;
  logic                               w_reload;
  logic                               w_dec;

  assign w_load = ~r_valid | out_ready;

  for (genvar p = 0; p < NUM_PRI; p++) begin : g_s1
    hqm_aw_rr_dwrr_arb_pipe_pick_first #(.N(NUM_REQS), .W(NUM_REQSB2)) u_pick (
      .i_req   (reqs[p*NUM_REQS +: NUM_REQS]),
      .i_idx   (r_idx[p]),
      .o_valid (w_pri_any[p]),
      .o_sel   (w_s1_sel[p])
    );
  end

  always_comb begin
    w_cand       = '0;
    w_reload_val = '0;
    for (int p = 0; p < NUM_PRI; p++) begin
      w_cand[p]       = w_pri_any[p] & (r_cred[p] != '0);
      w_reload_val[p] = (cfg_weight[p*8 +: 8] == 8'd0) ? CW'(1) : CW'(cfg_weight[p*8 +: 8]);
    end
  end

  // Fixed index NUM_PRI-1 turns the RR search into a lowest-numbered pick
  hqm_aw_rr_dwrr_arb_pipe_pick_first #(.N(NUM_PRI), .W(NUM_PRIB2)) u_strict (
    .i_req   (w_pri_any),
    .i_idx   (NUM_PRIB2'(NUM_PRI - 1)),
    .o_valid (w_strict_any),
    .o_sel   (w_strict_sel)
  );

  hqm_aw_rr_dwrr_arb_pipe_pick_first #(.N(NUM_PRI), .W(NUM_PRIB2)) u_cand (
    .i_req   (w_cand),
    .i_idx   (NUM_PRIB2'(NUM_PRI - 1)),
    .o_valid (w_cand_any),
    .o_sel   (w_cand_sel)
  );

  hqm_aw_rr_dwrr_arb_pipe_pick_first #(.N(NUM_PRI), .W(NUM_PRIB2)) u_boost (
    .i_req   (w_boost),
    .i_idx   (NUM_PRIB2'(NUM_PRI - 1)),
    .o_valid (w_boost_any),
    .o_sel   (w_boost_sel)
  );

  // Reloaded credits are all >= 1, so a reload cycle picks exactly like strict mode
  always_comb begin
    w_any       = w_strict_any;
    w_sel_pri   = w_strict_sel;
    w_boost_win = 1'b0;
    w_reload    = 1'b0;
    w_dec       = 1'b0;
    if (w_boost_any) begin
      w_sel_pri   = w_boost_sel;
      w_boost_win = 1'b1;
    end else if (aw_arb_mode_t'(cfg_mode) == HQM_AW_ARB_DWRR) begin
      w_dec = w_any;
      if (w_cand_any) w_sel_pri = w_cand_sel;
      else            w_reload  = w_any;
    end
  end

  assign w_win_req = w_s1_sel[w_sel_pri];
  assign w_win_oh  = w_any ? (NUM_PRI'(1) << w_sel_pri) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pri   <= '0;
      r_win   <= '0;
      r_boost <= 1'b0;
      for (int p = 0; p < NUM_PRI; p++) r_idx[p] <= NUM_REQSB2'(NUM_REQS - 1);
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_pri            <= w_sel_pri;
        r_win            <= w_win_req;
        r_boost          <= w_boost_win;
        r_idx[w_sel_pri] <= w_win_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cred <= '0;
    end else if (w_load) begin
      for (int p = 0; p < NUM_PRI; p++) begin
        if (w_reload)
          r_cred[p] <= (w_dec && w_win_oh[p]) ? w_reload_val[p] - CW'(1) : w_reload_val[p];
        else if (w_dec && w_win_oh[p])
          r_cred[p] <= r_cred[p] - CW'(1);
      end
    end
  end

`ifdef HQM_AW_RR_DWRR_ARB_STARVE_EN
  logic [NUM_PRI-1:0][7:0] r_age;

  always_comb begin
    w_boost = '0;
    for (int p = 0; p < NUM_PRI; p++)
      w_boost[p] = w_pri_any[p] && (cfg_starve_thresh != 8'd0) && (r_age[p] >= cfg_starve_thresh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (w_load) begin
      for (int p = 0; p < NUM_PRI; p++) begin
        if (w_pri_any[p] && !w_win_oh[p])
          r_age[p] <= (r_age[p] == 8'hff) ? r_age[p] : r_age[p] + 8'd1;
        else
          r_age[p] <= 8'd0;
      end
    end
  end
`else
  logic w_unused_thresh;
  assign w_boost         = '0;
  assign w_unused_thresh = ^cfg_starve_thresh;
`endif

  assign out_valid      = r_valid;
  assign winner_pri     = r_pri;
  assign winner         = r_win;
  assign winner_boosted = r_boost;

endmodule
